// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage: a 2-entry skid buffer with registered up_ready_o
// (SKID=1) or a single register with pass-through ready (SKID=0), plus stall/bubble counters.
module pipe_stage_reg #(
    parameter int DATA_W = 64,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              up_valid_i,
    input  logic [DATA_W-1:0] up_data_i,
    output logic              up_ready_o,
    output logic              dn_valid_o,
    output logic [DATA_W-1:0] dn_data_o,
    input  logic              dn_ready_i,
    output logic [1:0]        occ_o,
    input  logic              stat_clr_i,
    output logic [CNT_W-1:0]  bubble_cnt_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [DATA_W-1:0] head_r;
    logic [DATA_W-1:0] head_s;
    logic [DATA_W-1:0] skid_r;
    logic [DATA_W-1:0] skid_s;
    logic              up_ready_r;
    logic              up_ready_s;
    logic              accept_s;
    logic              release_s;
    logic [CNT_W-1:0]  bubble_r;
    logic [CNT_W-1:0]  bubble_s;
    logic [CNT_W-1:0]  stall_r;
    logic [CNT_W-1:0]  stall_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1'b1);
        end
    endfunction

    // The state encoding equals the occupancy, so outputs come straight from registers.
    assign occ_o        = state_r;
    assign dn_valid_o   = (state_r != ST_EMPTY);
    assign dn_data_o    = head_r;
    assign bubble_cnt_o = bubble_r;
    assign stall_cnt_o  = stall_r;

    generate
        if (SKID != 0) begin : g_skid
            assign up_ready_o = up_ready_r;
        end else begin : g_reg
            assign up_ready_o = ~rst & (~dn_valid_o | dn_ready_i);
        end
    endgenerate

    // Next-state and payload steering; flush outranks accept and release.
    always_comb begin
        state_s   = state_r;
        head_s    = head_r;
        skid_s    = skid_r;
        accept_s  = up_valid_i & up_ready_o;
        release_s = dn_valid_o & dn_ready_i;
        if (flush_i) begin
            state_s = ST_EMPTY;
            head_s  = {DATA_W{1'b0}};
            skid_s  = {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_s = ST_ONE;
                        head_s  = up_data_i;
                    end else begin
                        state_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && release_s) begin
                        head_s = up_data_i;
                    end else if (accept_s && (SKID != 0)) begin
                        state_s = ST_FULL;
                        skid_s  = up_data_i;
                    end else if (release_s) begin
                        // head_r keeps its last value while empty
                        state_s = ST_EMPTY;
                    end else begin
                        state_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (release_s) begin
                        state_s = ST_ONE;
                        head_s  = skid_r;
                    end else begin
                        state_s = ST_FULL;
                    end
                end
                default: begin
                    state_s = ST_EMPTY;
                end
            endcase
        end
        up_ready_s = (state_s != ST_FULL);
    end

    // Statistics counters: clear wins over a saturating increment.
    always_comb begin
        bubble_s = bubble_r;
        stall_s  = stall_r;
        if (stat_clr_i) begin
            bubble_s = {CNT_W{1'b0}};
            stall_s  = {CNT_W{1'b0}};
        end else begin
            if (!dn_valid_o) begin
                bubble_s = sat_inc(bubble_r);
            end else begin
                bubble_s = bubble_r;
            end
            if (up_valid_i && !up_ready_o) begin
                stall_s = sat_inc(stall_r);
            end else begin
                stall_s = stall_r;
            end
        end
    end

    // State, payload and counter registers; rst overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_EMPTY;
            head_r     <= {DATA_W{1'b0}};
            skid_r     <= {DATA_W{1'b0}};
            up_ready_r <= 1'b0;
            bubble_r   <= {CNT_W{1'b0}};
            stall_r    <= {CNT_W{1'b0}};
        end else begin
            state_r    <= state_s;
            head_r     <= head_s;
            skid_r     <= skid_s;
            up_ready_r <= up_ready_s;
            bubble_r   <= bubble_s;
            stall_r    <= stall_s;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: accepted payloads are queued per instance and a monitor
// compares every released head against the queue; directed checks cover state/counters.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst;

    logic        a_flush, a_up_valid, a_up_ready, a_dn_valid, a_dn_ready, a_clr;
    logic [63:0] a_up_data, a_dn_data;
    logic [1:0]  a_occ;
    logic [3:0]  a_bub, a_stl;

    logic        b_flush, b_up_valid, b_up_ready, b_dn_valid, b_dn_ready, b_clr;
    logic [63:0] b_up_data, b_dn_data;
    logic [1:0]  b_occ;
    logic [3:0]  b_bub, b_stl;

    logic [63:0] qa[$];
    logic [63:0] qb[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(64), .SKID(1), .CNT_W(4)) u_skid (
        .clk(clk), .rst(rst), .flush_i(a_flush),
        .up_valid_i(a_up_valid), .up_data_i(a_up_data), .up_ready_o(a_up_ready),
        .dn_valid_o(a_dn_valid), .dn_data_o(a_dn_data), .dn_ready_i(a_dn_ready),
        .occ_o(a_occ), .stat_clr_i(a_clr), .bubble_cnt_o(a_bub), .stall_cnt_o(a_stl)
    );

    pipe_stage_reg #(.DATA_W(64), .SKID(0), .CNT_W(4)) u_reg (
        .clk(clk), .rst(rst), .flush_i(b_flush),
        .up_valid_i(b_up_valid), .up_data_i(b_up_data), .up_ready_o(b_up_ready),
        .dn_valid_o(b_dn_valid), .dn_data_o(b_dn_data), .dn_ready_i(b_dn_ready),
        .occ_o(b_occ), .stat_clr_i(b_clr), .bubble_cnt_o(b_bub), .stall_cnt_o(b_stl)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Releases are compared against the scoreboard; flush/reset cycles release nothing.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst && !a_flush && a_dn_valid && a_dn_ready) begin
                if (qa.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL a_unexpected: got %0h expected none", a_dn_data);
                end else begin
                    chk("a_order", a_dn_data, qa.pop_front());
                end
            end
            if (!rst && !b_flush && b_dn_valid && b_dn_ready) begin
                if (qb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL b_unexpected: got %0h expected none", b_dn_data);
                end else begin
                    chk("b_order", b_dn_data, qb.pop_front());
                end
            end
        end
    endtask

    // Record accepts at mid-cycle, then advance to just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        if (rst) begin
            qa.delete();
            qb.delete();
        end else begin
            if (a_flush) qa.delete();
            else if (a_up_valid && a_up_ready) qa.push_back(a_up_data);
            if (b_flush) qb.delete();
            else if (b_up_valid && b_up_ready) qb.push_back(b_up_data);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit [4:0]    rdy_seq = 5'b11011;
        bit [4:0]    vld_seq = 5'b01111;
        bit [4:0]    exp_rdy = 5'b11011;
        bit [4:0]    exp_occ = 5'b01111;
        logic [63:0] d;

        rst = 1'b1;
        a_flush = 1'b0; a_up_valid = 1'b0; a_up_data = 64'd0; a_dn_ready = 1'b0; a_clr = 1'b0;
        b_flush = 1'b0; b_up_valid = 1'b0; b_up_data = 64'd0; b_dn_ready = 1'b0; b_clr = 1'b0;
        fork
            monitor();
        join_none

        // reset state
        repeat (3) tick();
        chk("rst_a_ready", a_up_ready, 64'd0);
        chk("rst_a_occ", a_occ, 64'd0);
        chk("rst_a_valid", a_dn_valid, 64'd0);
        chk("rst_a_data", a_dn_data, 64'd0);
        chk("rst_a_bub", a_bub, 64'd0);
        chk("rst_a_stl", a_stl, 64'd0);
        chk("rst_b_ready", b_up_ready, 64'd0);
        chk("rst_b_bub", b_bub, 64'd0);
        chk("rst_b_stl", b_stl, 64'd0);
        rst = 1'b0;
        #1;
        chk("b_ready_after_rst", b_up_ready, 64'd1);
        tick();
        chk("a_ready_after_rst", a_up_ready, 64'd1);

        // back-to-back 1,2,3 with dn_ready held high
        a_dn_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            a_up_valid = 1'b1;
            a_up_data  = 64'(i);
            tick();
            chk("b2b_occ", a_occ, 64'd1);
            chk("b2b_valid", a_dn_valid, 64'd1);
            chk("b2b_data", a_dn_data, 64'(i));
        end
        a_up_valid = 1'b0;
        tick();
        chk("drain_valid", a_dn_valid, 64'd0);
        chk("drain_hold_data", a_dn_data, 64'd3);
        chk("drain_occ", a_occ, 64'd0);
        chk("b2b_stall", a_stl, 64'd0);

        // fill the skid buffer and hold C off
        a_dn_ready = 1'b0;
        a_up_valid = 1'b1; a_up_data = 64'hAA; a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        chk("fill_occ1", a_occ, 64'd1);
        a_up_data = 64'hBB;
        tick();
        chk("fill_occ2", a_occ, 64'd2);
        chk("full_ready", a_up_ready, 64'd0);
        a_up_data = 64'hCC;
        tick();
        chk("stall_1", a_stl, 64'd1);
        chk("full_occ", a_occ, 64'd2);
        tick();
        chk("stall_2", a_stl, 64'd2);
        chk("stable_data", a_dn_data, 64'hAA);
        chk("stable_valid", a_dn_valid, 64'd1);
        a_dn_ready = 1'b1;
        tick();
        chk("stall_3", a_stl, 64'd3);
        chk("skid_to_head", a_dn_data, 64'hBB);
        chk("ready_reopen", a_up_ready, 64'd1);
        tick();
        chk("c_head", a_dn_data, 64'hCC);
        chk("c_occ", a_occ, 64'd1);
        a_up_valid = 1'b0;
        tick();
        chk("abc_empty", a_occ, 64'd0);

        // flush in FULL with a same-cycle offer and release
        a_dn_ready = 1'b0;
        a_up_valid = 1'b1; a_up_data = 64'h11;
        tick();
        a_up_data = 64'h22;
        tick();
        chk("pre_flush_occ", a_occ, 64'd2);
        a_flush = 1'b1; a_up_data = 64'h33; a_dn_ready = 1'b1;
        tick();
        a_flush = 1'b0; a_up_valid = 1'b0;
        chk("flush_occ", a_occ, 64'd0);
        chk("flush_valid", a_dn_valid, 64'd0);
        chk("flush_data", a_dn_data, 64'd0);
        chk("flush_queue", 64'(qa.size()), 64'd0);
        chk("flush_ready", a_up_ready, 64'd1);
        chk("flush_keeps_stall", a_stl, 64'd4);
        a_up_valid = 1'b1; a_up_data = 64'h44;
        tick();
        chk("post_flush_data", a_dn_data, 64'h44);
        a_up_valid = 1'b0;
        tick();

        // reset in FULL together with flush
        a_dn_ready = 1'b0;
        a_up_valid = 1'b1; a_up_data = 64'h55;
        tick();
        a_up_data = 64'h66;
        tick();
        chk("pre_rst_occ", a_occ, 64'd2);
        rst = 1'b1; a_flush = 1'b1; a_clr = 1'b0; a_up_data = 64'h77; a_dn_ready = 1'b1;
        tick();
        chk("midrst_occ", a_occ, 64'd0);
        chk("midrst_valid", a_dn_valid, 64'd0);
        chk("midrst_data", a_dn_data, 64'd0);
        chk("midrst_bub", a_bub, 64'd0);
        chk("midrst_stl", a_stl, 64'd0);
        chk("midrst_ready", a_up_ready, 64'd0);
        a_flush = 1'b0;
        tick();
        chk("midrst_ready2", a_up_ready, 64'd0);
        chk("midrst_no_accept", a_occ, 64'd0);
        chk("midrst_b_ready", b_up_ready, 64'd0);
        rst = 1'b0; a_up_valid = 1'b0; a_dn_ready = 1'b0;
        tick();
        chk("post_rst_ready", a_up_ready, 64'd1);

        // bubble counter saturation and clear priority
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        chk("bub_clr", a_bub, 64'd0);
        repeat (14) tick();
        chk("bub_14", a_bub, 64'd14);
        repeat (6) tick();
        chk("bub_sat", a_bub, 64'd15);
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        chk("bub_clr_wins", a_bub, 64'd0);
        tick();
        chk("bub_resume", a_bub, 64'd1);

        // SKID=0: ready follows dn_ready combinationally
        d = 64'h100;
        for (int i = 0; i < 5; i++) begin
            b_dn_ready = rdy_seq[i];
            b_up_valid = vld_seq[i];
            b_up_data  = d;
            #1;
            chk("reg_ready", b_up_ready, 64'(exp_rdy[i]));
            if (vld_seq[i] && exp_rdy[i]) d = d + 64'd1;
            tick();
            chk("reg_occ", b_occ, 64'(exp_occ[i]));
        end
        b_up_valid = 1'b0;
        tick();

        chk("a_queue_empty", 64'(qa.size()), 64'd0);
        chk("b_queue_empty", 64'(qb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
